alu_writeback: RTL



---
 rtl/alu_writeback.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Registered ALU result stage: owns the architectural flags and writes 8-bit or 16-bit pair results to the register file.
// Optional forwarding ports are compiled in with `define ALU_WB_FWD_EN.
module alu_writeback #(
   parameter int DATA_W  = 8,
   parameter int FLAGS_W = 4,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_lo,
   input  logic [DATA_W-1:0]  in_hi,
   input  logic [FLAGS_W-1:0] in_flags,
   input  logic [IDX_W-1:0]   in_dest,
   input  logic               in_pair,
   input  logic               in_wr_data,
   input  logic               in_wr_flags,
   input  logic               flags_wr_en,
   input  logic [FLAGS_W-1:0] flags_wr_data,
   output logic [FLAGS_W-1:0] flags_q,
   output logic               rf_we,
   output logic [IDX_W-1:0]   rf_idx,
   output logic [DATA_W-1:0]  rf_data,
   output logic               busy
`ifdef ALU_WB_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [IDX_W-1:0]   fwd_idx,
   output logic [DATA_W-1:0]  fwd_data
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      WR_LO,
      WR_HI
   } state_t;

   state_t             state_q;
   logic [DATA_W-1:0]  hi_q;
   logic [IDX_W-1:0]   dest_q;
   logic               pair_q;
   logic               wr_q;
   logic               accept;

   always_comb begin
      in_ready = (state_q == IDLE) || (state_q == WR_HI) || ((state_q == WR_LO) && !pair_q);
      busy     = (state_q != IDLE);
      accept   = in_valid && in_ready;
   end

   // The low half goes straight into rf_data on accept, so rf_data doubles as the lo holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hi_q    <= '0;
         dest_q  <= '0;
         pair_q  <= 1'b0;
         wr_q    <= 1'b0;
         flags_q <= '0;
         rf_we   <= 1'b0;
         rf_idx  <= '0;
         rf_data <= '0;
      end else begin
         if (accept && in_wr_flags) begin
            flags_q <= in_flags;
         end else if (flags_wr_en) begin
            flags_q <= flags_wr_data;
         end

         if (accept) begin
            state_q <= WR_LO;
            hi_q    <= in_hi;
            dest_q  <= in_dest;
            pair_q  <= in_pair;
            wr_q    <= in_wr_data;
            rf_we   <= in_wr_data;
            rf_idx  <= in_dest;
            rf_data <= in_lo;
         end else if ((state_q == WR_LO) && pair_q) begin
            state_q <= WR_HI;
            rf_we   <= wr_q;
            rf_idx  <= dest_q + 1'b1;
            rf_data <= hi_q;
         end else begin
            state_q <= IDLE;
            rf_we   <= 1'b0;
         end
      end
   end

`ifdef ALU_WB_FWD_EN
   always_comb begin
      fwd_valid = rf_we;
      fwd_idx   = rf_idx;
      fwd_data  = rf_data;
   end
`endif

endmodule
